fir_mac_scheduler: RTL and testbench

//  Time-multiplexed FIR controller: stores samples in an N_TAPS-deep circular buffer and holds a

---
 rtl/fir_mac_scheduler_if.sv | 32 +++
 rtl/fir_mac_scheduler.sv | 88 ++++++++
 tb/tb_fir_mac_scheduler.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_scheduler_if.sv
// fir_mac_scheduler_if: sample/coefficient/output bundle for the time-multiplexed FIR controller
// Ports:
//   x_valid/x_ready/x_in           sample handshake (source -> controller)
//   coef_we/coef_addr/coef_data    coefficient write port, honoured only while not busy
//   y_valid/y_out                  one-cycle output pulse with held filtered value
//   busy                           controller is in MAC or OUT
// Modports: master = sample/coefficient source, slave = fir_mac_scheduler.
interface fir_mac_scheduler_if #(
    parameter int N_TAPS  = 10,
    parameter int BW_in   = 6,
    parameter int BW_out  = 6,
    parameter int BW_coef = 4
);
    localparam int AW = $clog2(N_TAPS);
    logic                      x_valid;
    logic                      x_ready;
    logic signed [BW_in-1:0]   x_in;
    logic                      coef_we;
    logic [AW-1:0]             coef_addr;
    logic signed [BW_coef-1:0] coef_data;
    logic                      y_valid;
    logic signed [BW_out-1:0]  y_out;
    logic                      busy;
    modport master (
        output x_valid, x_in, coef_we, coef_addr, coef_data,
        input  x_ready, y_valid, y_out, busy
    );
    modport slave (
        input  x_valid, x_in, coef_we, coef_addr, coef_data,
        output x_ready, y_valid, y_out, busy
    );
endinterface

// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: FIR filter sharing one signed MAC across N_TAPS taps, one output per sample
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    fir_mac_scheduler_if.slave (sample handshake, coefficient writes, output, busy)
// Option macro FIR_SAT_EN: when defined the output saturates to the BW_out range,
// otherwise the low BW_out bits of the shifted accumulator are kept (two's-complement wrap).
module fir_mac_scheduler #(
    parameter int N_TAPS    = 10,
    parameter int BW_in     = 6,
    parameter int BW_out    = 6,
    parameter int BW_coef   = 4,
    parameter int OUT_SHIFT = 0
) (
    input logic clk,
    input logic reset,
    fir_mac_scheduler_if.slave bus
);
    localparam int AW    = $clog2(N_TAPS);
    localparam int PW    = BW_in + BW_coef;
    localparam int ACC_W = PW + AW;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    logic [1:0]                state;
    logic signed [BW_in-1:0]   sbuf [N_TAPS];
    logic signed [BW_coef-1:0] coef [N_TAPS];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             k;
    logic [AW-1:0]             rd_ptr;
    logic signed [ACC_W-1:0]   acc;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [BW_out-1:0]  y_fmt;
    logic                      coef_wr;
    logic                      last_tap;
    assign bus.x_ready = state == S_IDLE;
    assign bus.busy    = state != S_IDLE;
    // Out-of-range addresses are dropped; the extra bit keeps the compare exact when N_TAPS is a power of two.
    assign coef_wr     = bus.coef_we && state == S_IDLE && {1'b0, bus.coef_addr} < (AW + 1)'(N_TAPS);
    assign last_tap    = k == AW'(N_TAPS - 1);
    always_comb begin
        // wr_ptr - k modulo N_TAPS; the AW-bit wrap of the add cancels because the result is < N_TAPS.
        rd_ptr  = wr_ptr >= k ? wr_ptr - k : wr_ptr + AW'(N_TAPS) - k;
        prod    = sbuf[rd_ptr] * coef[k];
        shifted = acc >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
        y_fmt   = shifted > ACC_W'((1 << (BW_out - 1)) - 1) ? BW_out'((1 << (BW_out - 1)) - 1) :
                  shifted < ACC_W'(-(1 << (BW_out - 1)))    ? BW_out'(-(1 << (BW_out - 1)))   :
                  BW_out'(shifted);
`else
        y_fmt   = BW_out'(shifted);
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            k           <= '0;
            acc         <= '0;
            bus.y_out   <= '0;
            bus.y_valid <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                sbuf[i] <= '0;
                coef[i] <= BW_coef'(i == N_TAPS - 1);
            end
        end else begin
            bus.y_valid <= 1'b0;
            if (coef_wr)
                coef[bus.coef_addr] <= bus.coef_data;
            if (state == S_IDLE && bus.x_valid) begin
                sbuf[wr_ptr] <= bus.x_in;
                acc          <= '0;
                k            <= '0;
                state        <= S_MAC;
            end else if (state == S_MAC) begin
                acc   <= acc + ACC_W'(prod);
                k     <= last_tap ? '0 : k + AW'(1);
                state <= last_tap ? S_OUT : S_MAC;
            end else if (state == S_OUT) begin
                bus.y_out   <= y_fmt;
                bus.y_valid <= 1'b1;
                wr_ptr      <= wr_ptr == AW'(N_TAPS - 1) ? '0 : wr_ptr + AW'(1);
                state       <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb_fir_mac_scheduler: directed self-checking bench for fir_mac_scheduler (default parameters)
module tb_fir_mac_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    fir_mac_scheduler_if bus ();
    fir_mac_scheduler dut (.clk(clk), .reset(reset), .bus(bus));
    task automatic idle_inputs;
        bus.x_valid   = 1'b0;
        bus.x_in      = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
    endtask
    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic write_coef(input int a, input int d);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'(a);
        bus.coef_data = 4'(d);
        @(negedge clk);
        bus.coef_we   = 1'b0;
    endtask
    // Offers one sample at a negedge, returns the next output and the negedges from offer to y_valid.
    task automatic send(input int x, output int y, output int lat);
        int n = 0;
        while (!bus.x_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        bus.x_valid = 1'b1;
        bus.x_in    = 6'(x);
        @(negedge clk);
        bus.x_valid = 1'b0;
        lat = 1;
        while (!bus.y_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        y = bus.y_out;
    endtask
    task automatic test_reset;
        do_reset();
        tests++; if (bus.x_ready !== 1'b1) begin fails++; $display("FAIL reset_x_ready: got %b expected 1", bus.x_ready); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.y_valid !== 1'b0) begin fails++; $display("FAIL reset_y_valid: got %b expected 0", bus.y_valid); end
        tests++; if (bus.y_out !== 6'sd0) begin fails++; $display("FAIL reset_y_out: got %0d expected 0", bus.y_out); end
    endtask
    task automatic test_back_to_back;
        int y, lat, e;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            send(i, y, lat);
            e = i <= 9 ? 0 : i - 9;
            tests++;
            if (y !== e || lat != 12) begin
                fails++;
                $display("FAIL delay_line[%0d]: got y=%0d lat=%0d expected y=%0d lat=12", i, y, lat, e);
            end
        end
    endtask
    task automatic test_impulse;
        int y, lat, e;
        do_reset();
        for (int a = 0; a < 10; a++) write_coef(a, 1);
        for (int i = 0; i <= 10; i++) begin
            send(i == 0 ? 5 : 0, y, lat);
            e = i < 10 ? 5 : 0;
            tests++;
            if (y !== e || lat != 12) begin
                fails++;
                $display("FAIL impulse[%0d]: got y=%0d lat=%0d expected y=%0d lat=12", i, y, lat, e);
            end
        end
    endtask
    task automatic test_overflow;
        int y, lat, e1, e10;
`ifdef FIR_SAT_EN
        e1 = 31; e10 = 31;
`else
        e1 = 25; e10 = -6;
`endif
        do_reset();
        for (int a = 0; a < 10; a++) write_coef(a, 7);
        for (int i = 1; i <= 10; i++) begin
            send(31, y, lat);
            if (i == 1) begin
                tests++;
                if (y !== e1) begin fails++; $display("FAIL overflow_first: got %0d expected %0d", y, e1); end
            end
        end
        tests++;
        if (y !== e10) begin fails++; $display("FAIL overflow_tenth: got %0d expected %0d", y, e10); end
    endtask
    task automatic test_hold_valid;
        int readies = 0;
        int yt[$];
        logic ready_in_mac;
        do_reset();
        bus.x_valid = 1'b1;
        bus.x_in    = 6'sd2;
        ready_in_mac = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (bus.x_ready) readies++;
            if (bus.y_valid) yt.push_back(t);
            if (t == 1) ready_in_mac = bus.x_ready;
            @(negedge clk);
        end
        bus.x_valid = 1'b0;
        tests++; if (ready_in_mac !== 1'b0) begin fails++; $display("FAIL hold_ready_in_mac: got %b expected 0", ready_in_mac); end
        tests++; if (readies != 4) begin fails++; $display("FAIL hold_accepts: got %0d expected 4", readies); end
        tests++;
        if (yt.size() != 3) begin
            fails++;
            $display("FAIL hold_pulses: got %0d expected 3", yt.size());
        end else begin
            if (yt[0] != 12 || yt[1] - yt[0] != 12 || yt[2] - yt[1] != 12) begin
                fails++;
                $display("FAIL hold_spacing: got %0d,%0d,%0d expected 12,24,36", yt[0], yt[1], yt[2]);
            end
        end
        repeat (14) @(negedge clk);
    endtask
    task automatic test_coef_busy;
        int y, lat;
        do_reset();
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'd0;
        bus.coef_data = 4'sd2;
        bus.x_valid   = 1'b1;
        bus.x_in      = -6'sd4;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        bus.coef_we   = 1'b1;
        bus.coef_data = 4'sd3;
        @(negedge clk);
        bus.coef_we   = 1'b0;
        lat = 0;
        while (!bus.y_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        y = bus.y_out;
        tests++;
        if (y !== -8) begin fails++; $display("FAIL coef_with_accept: got %0d expected -8", y); end
        send(-4, y, lat);
        tests++;
        if (y !== -8) begin fails++; $display("FAIL coef_we_busy_ignored: got %0d expected -8", y); end
        write_coef(0, 3);
        send(1, y, lat);
        tests++;
        if (y !== 3) begin fails++; $display("FAIL coef_we_idle: got %0d expected 3", y); end
    endtask
    task automatic test_reset_abort;
        int y, lat, e, pulses;
        do_reset();
        write_coef(9, 0);
        write_coef(8, 1);
        write_coef(0, 1);
        for (int i = 0; i < 3; i++) send(7, y, lat);
        tests++;
        if (y !== 7) begin fails++; $display("FAIL abort_setup: got %0d expected 7", y); end
        bus.x_valid = 1'b1;
        bus.x_in    = 6'sd9;
        @(negedge clk);
        bus.x_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if (bus.x_ready !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL abort_state: got ready=%b busy=%b expected ready=1 busy=0", bus.x_ready, bus.busy); end
        tests++; if (bus.y_out !== 6'sd0) begin fails++; $display("FAIL abort_y_out: got %0d expected 0", bus.y_out); end
        pulses = 0;
        for (int t = 0; t < 15; t++) begin
            if (bus.y_valid) pulses++;
            @(negedge clk);
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL abort_no_pulse: got %0d expected 0", pulses); end
        for (int i = 1; i <= 10; i++) begin
            send(i == 1 ? 3 : 0, y, lat);
            e = i == 10 ? 3 : 0;
            tests++;
            if (y !== e) begin fails++; $display("FAIL abort_after[%0d]: got %0d expected %0d", i, y, e); end
        end
    endtask
    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_impulse();
        test_overflow();
        test_hold_valid();
        test_coef_busy();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
